// File: rtl/arbiter_rr_nreq.sv
// Round-robin arbiter for NUM_REQ requesters. Priority rotates past the
// last served requester, and all grant outputs are registered. When
// LOCK_EN=1, the arbiter can hold a grant on its current owner until that
// owner signals end-of-packet or drops its request.
module arbiter_rr_nreq #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned GRANT_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  parameter int unsigned LOCK_EN = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_en,
  input  logic               i_valid,
  input  logic [NUM_REQ-1:0] i_req_bus,
  input  logic               i_last,
  output logic               o_valid,
  output logic [GRANT_W-1:0] o_grant_idx,
  output logic [NUM_REQ-1:0] o_grant_onehot,
  output logic               o_locked
);

  localparam logic [GRANT_W-1:0] LAST_RST = GRANT_W'(NUM_REQ - 1);
  localparam bit                 LOCK     = (LOCK_EN != 0);

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t             state;
  logic [GRANT_W-1:0] last_q;

  logic               active_c;
  logic               owner_req_c;
  logic               win_found_c;
  logic [GRANT_W-1:0] win_idx_c;
  logic [GRANT_W-1:0] cand_c;

  assign active_c    = i_en & i_valid;
  assign owner_req_c = i_req_bus[last_q];

  // Scan upward from the slot after last_q, wrapping around, and take the first requester found
  always_comb begin
    win_found_c = 1'b0;
    win_idx_c   = '0;
    cand_c      = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand_c = GRANT_W'((32'(last_q) + off) % NUM_REQ);
      if (!win_found_c && i_req_bus[cand_c]) begin
        win_found_c = 1'b1;
        win_idx_c   = cand_c;
      end
    end
  end

  // Arbitration/lock state machine with registered grant outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_ARB;
      last_q         <= LAST_RST;
      o_valid        <= 1'b0;
      o_grant_idx    <= '0;
      o_grant_onehot <= '0;
      o_locked       <= 1'b0;
    end else if (!active_c) begin
      // While idle, clear the outputs and drop any lock; keep the rotation point
      state          <= ST_ARB;
      o_valid        <= 1'b0;
      o_grant_idx    <= '0;
      o_grant_onehot <= '0;
      o_locked       <= 1'b0;
    end else if (state == ST_HOLD && owner_req_c && !i_last) begin
      // The owner is still mid-packet: keep the current grant
      state <= ST_HOLD;
    end else if (win_found_c) begin
      state          <= LOCK ? ST_HOLD : ST_ARB;
      last_q         <= win_idx_c;
      o_valid        <= 1'b1;
      o_grant_idx    <= win_idx_c;
      o_grant_onehot <= NUM_REQ'(1) << win_idx_c;
      o_locked       <= LOCK;
    end else begin
      state          <= ST_ARB;
      o_valid        <= 1'b0;
      o_grant_idx    <= '0;
      o_grant_onehot <= '0;
      o_locked       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_arbiter_rr_nreq.sv
// Bench for arbiter_rr_nreq. It runs a free-rotating instance and a
// packet-lock instance side by side on the same stimulus, and scoreboards
// both against a behavioural model.
module tb_arbiter_rr_nreq;

  localparam int unsigned N = 4;
  localparam int unsigned GW = 2;

  logic          clk;
  logic          rst;
  logic          en;
  logic          vld;
  logic [N-1:0]  req;
  logic          last;

  logic          v0, v1, lk0, lk1;
  logic [GW-1:0] idx0, idx1;
  logic [N-1:0]  oh0, oh1;

  arbiter_rr_nreq #(.NUM_REQ(N), .LOCK_EN(0)) u_free (
    .clk(clk), .rst(rst), .i_en(en), .i_valid(vld), .i_req_bus(req), .i_last(last),
    .o_valid(v0), .o_grant_idx(idx0), .o_grant_onehot(oh0), .o_locked(lk0)
  );

  arbiter_rr_nreq #(.NUM_REQ(N), .LOCK_EN(1)) u_lock (
    .clk(clk), .rst(rst), .i_en(en), .i_valid(vld), .i_req_bus(req), .i_last(last),
    .o_valid(v1), .o_grant_idx(idx1), .o_grant_onehot(oh1), .o_locked(lk1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          v;
    logic [GW-1:0] idx;
    logic [N-1:0]  oh;
    logic          lk;
    string         tag;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int n_cmp = 0;
  int n_bad = 0;
  bit stim_done = 1'b0;

  // Behavioural model state per instance (0 = free, 1 = locking)
  int m_last [2];
  bit m_hold [2];
  bit m_v    [2];
  int m_idx  [2];
  bit m_lk   [2];

  function automatic int pick(input int from, input logic [N-1:0] r);
    for (int k = 1; k <= int'(N); k++) begin
      int j;
      j = (from + k) % int'(N);
      if (r[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_step(input int d, input bit lock_mode, input logic r_rst,
                            input logic r_act, input logic [N-1:0] r_req, input logic r_last);
    int w;
    if (r_rst) begin
      m_v[d] = 0; m_idx[d] = 0; m_hold[d] = 0; m_lk[d] = 0; m_last[d] = int'(N) - 1;
    end else if (!r_act) begin
      m_v[d] = 0; m_idx[d] = 0; m_hold[d] = 0; m_lk[d] = 0;
    end else if (m_hold[d] && r_req[m_last[d]] && !r_last) begin
      // Grant is held on the owner
    end else begin
      w = pick(m_last[d], r_req);
      if (w >= 0) begin
        m_v[d] = 1; m_idx[d] = w; m_last[d] = w; m_hold[d] = lock_mode; m_lk[d] = lock_mode;
      end else begin
        m_v[d] = 0; m_idx[d] = 0; m_hold[d] = 0; m_lk[d] = 0;
      end
    end
  endtask

  function automatic exp_t snap(input int d, input string tag);
    exp_t e;
    e.v   = m_v[d];
    e.idx = GW'(m_idx[d]);
    e.oh  = m_v[d] ? (N'(1) << m_idx[d]) : '0;
    e.lk  = m_lk[d];
    e.tag = tag;
    return e;
  endfunction

  // Drive one cycle of stimulus at the negedge and queue its expected response
  task automatic drive(input logic a_rst, input logic a_en, input logic a_vld,
                       input logic [N-1:0] a_req, input logic a_last, input string tag);
    @(negedge clk);
    rst = a_rst; en = a_en; vld = a_vld; req = a_req; last = a_last;
    model_step(0, 1'b0, a_rst, a_en & a_vld, a_req, a_last);
    model_step(1, 1'b1, a_rst, a_en & a_vld, a_req, a_last);
    q0.push_back(snap(0, tag));
    q1.push_back(snap(1, tag));
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  // Monitor: after each active edge, pop the expectation for that edge and compare it
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        cmp({e.tag, " free.valid"}, 32'(v0), 32'(e.v));
        cmp({e.tag, " free.idx"}, 32'(idx0), 32'(e.idx));
        cmp({e.tag, " free.onehot"}, 32'(oh0), 32'(e.oh));
        cmp({e.tag, " free.locked"}, 32'(lk0), 32'(e.lk));
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        cmp({e.tag, " lock.valid"}, 32'(v1), 32'(e.v));
        cmp({e.tag, " lock.idx"}, 32'(idx1), 32'(e.idx));
        cmp({e.tag, " lock.onehot"}, 32'(oh1), 32'(e.oh));
        cmp({e.tag, " lock.locked"}, 32'(lk1), 32'(e.lk));
      end
    end
  end

  // Stimulus: directed scenarios first, then random traffic
  initial begin
    rst = 1'b1; en = 1'b0; vld = 1'b0; req = '0; last = 1'b0;
    for (int d = 0; d < 2; d++) begin
      m_last[d] = int'(N) - 1; m_hold[d] = 0; m_v[d] = 0; m_idx[d] = 0; m_lk[d] = 0;
    end

    drive(1, 0, 0, 4'b0000, 0, "reset");
    for (int i = 0; i < 8; i++) drive(0, 1, 1, 4'b1111, 0, "all_req");

    drive(0, 1, 1, 4'b0010, 0, "set_last1");
    for (int i = 0; i < 4; i++) drive(0, 1, 1, 4'b1010, 0, "alt_1010");
    drive(0, 1, 1, 4'b0000, 0, "no_req");

    drive(1, 1, 1, 4'b0000, 0, "reset2");
    for (int i = 0; i < 3; i++) drive(0, 1, 1, 4'b0011, 0, "lock_hold");
    drive(0, 1, 1, 4'b0011, 1, "lock_last");
    for (int i = 0; i < 2; i++) drive(0, 1, 1, 4'b0011, 0, "lock_next");

    drive(1, 1, 1, 4'b0000, 0, "reset3");
    drive(0, 1, 1, 4'b0100, 0, "own2");
    for (int i = 0; i < 2; i++) drive(0, 1, 1, 4'b0101, 0, "own2_hold");
    for (int i = 0; i < 2; i++) drive(0, 1, 1, 4'b0001, 0, "owner_drop");

    drive(1, 1, 1, 4'b0000, 0, "reset4");
    drive(0, 1, 1, 4'b0100, 0, "grant2");
    for (int i = 0; i < 2; i++) drive(0, 0, 1, 4'b1111, 0, "en_low");
    for (int i = 0; i < 2; i++) drive(0, 1, 1, 4'b1111, 0, "resume");

    for (int i = 0; i < 2; i++) drive(0, 1, 1, 4'b0011, 0, "pre_rst_hold");
    drive(1, 1, 1, 4'b1111, 0, "rst_in_hold");
    drive(0, 1, 1, 4'b1111, 0, "post_rst");

    for (int i = 0; i < 800; i++) begin
      logic r_rst, r_en, r_vld, r_last;
      logic [N-1:0] r_req;
      r_rst  = ($urandom_range(0, 99) == 0);
      r_en   = ($urandom_range(0, 9) != 0);
      r_vld  = ($urandom_range(0, 9) != 0);
      r_last = ($urandom_range(0, 3) == 0);
      r_req  = ($urandom_range(0, 4) == 0) ? N'(0) : N'($urandom);
      drive(r_rst, r_en, r_vld, r_req, r_last, "random");
    end

    drive(0, 0, 0, 4'b0000, 0, "idle");
    stim_done = 1'b1;
  end

  // Finish once the scoreboard drains, or flag a timeout
  initial begin
    int budget;
    budget = 0;
    while (!(stim_done && q0.size() == 0 && q1.size() == 0) && budget < 5000) begin
      @(posedge clk);
      budget++;
    end
    #5;
    if (budget >= 5000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: scoreboard not drained, %0d entries left expected 0", q0.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
